// File: rtl/dcache_port_arbiter_if.sv
// Bundled requester-side and cache-side signals of the data-cache port arbiter.
// slave = arbiter view, master = requesters plus cache view.
interface dcache_port_arbiter_if #(
  parameter int NUM_REQ = 2
);
  // Handshake: requester k is pending while i_req_read[k] or i_req_write[k] is
  // high; its fields stay stable until o_req_done[k] pulses, and it drops the
  // request in that same cycle. Toward the cache, o_cache_read/o_cache_write
  // stay high with constant fields until i_cache_hit (read) or i_cache_ready
  // (write) is sampled high.
  logic [NUM_REQ-1:0]    i_req_read;
  logic [NUM_REQ-1:0]    i_req_write;
  logic [NUM_REQ*32-1:0] i_req_address;
  logic [NUM_REQ*32-1:0] i_req_wdata;
  logic [NUM_REQ-1:0]    i_req_tag;
  logic [NUM_REQ*2-1:0]  i_req_store_type;
  logic [NUM_REQ-1:0]    o_req_done;
  logic [31:0]           o_req_rdata;
  logic                  o_req_error;
  logic [31:0]           o_cache_address;
  logic [31:0]           o_cache_dout;
  logic                  o_cache_read;
  logic                  o_cache_write;
  logic                  o_cache_tag;
  logic [1:0]            o_cache_store_type;
  logic [31:0]           i_cache_din;
  logic                  i_cache_hit;
  logic                  i_cache_ready;

  modport slave (
    input  i_req_read, i_req_write, i_req_address, i_req_wdata, i_req_tag,
           i_req_store_type, i_cache_din, i_cache_hit, i_cache_ready,
    output o_req_done, o_req_rdata, o_req_error, o_cache_address, o_cache_dout,
           o_cache_read, o_cache_write, o_cache_tag, o_cache_store_type
  );

  modport master (
    output i_req_read, i_req_write, i_req_address, i_req_wdata, i_req_tag,
           i_req_store_type, i_cache_din, i_cache_hit, i_cache_ready,
    input  o_req_done, o_req_rdata, o_req_error, o_cache_address, o_cache_dout,
           o_cache_read, o_cache_write, o_cache_tag, o_cache_store_type
  );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing one data-cache port among NUM_REQ requesters.
// Optional BUSY watchdog enabled by defining DCACHE_ARB_TIMEOUT_EN.
module dcache_port_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  dcache_port_arbiter_if.slave   bus,
  output logic [1:0]             o_dbg_state
);
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("dcache_port_arbiter: illegal NUM_REQ or TIMEOUT_CYCLES");
  end

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d, grant_q, grant_d, grant_next;
  logic [NUM_REQ-1:0]  done_q, done_d, pending;
  logic [31:0]         rdata_q, rdata_d, addr_q, addr_d, dout_q, dout_d;
  logic                read_q, read_d, write_q, write_d, tag_q, tag_d;
  logic [1:0]          st_q, st_d;
  logic                found, complete, expire;
  logic [PW-1:0]       sel;
  int                  idx;

  assign pending    = bus.i_req_read | bus.i_req_write;
  assign complete   = (read_q & bus.i_cache_hit) | (write_q & bus.i_cache_ready);
  assign grant_next = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;

  // First pending requester at or above the pointer, wrapping past NUM_REQ-1.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    done_d  = done_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    read_d  = read_q;
    write_d = write_q;
    tag_d   = tag_q;
    st_d    = st_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = sel;
          addr_d  = bus.i_req_address[int'(sel)*32 +: 32];
          dout_d  = bus.i_req_wdata[int'(sel)*32 +: 32];
          write_d = bus.i_req_write[sel];
          read_d  = ~bus.i_req_write[sel];
          tag_d   = bus.i_req_tag[sel];
          st_d    = bus.i_req_store_type[int'(sel)*2 +: 2];
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (complete || expire) begin
          done_d  = NUM_REQ'(1) << grant_q;
          rdata_d = (complete && read_q) ? bus.i_cache_din : '0;
          addr_d  = '0;
          dout_d  = '0;
          read_d  = 1'b0;
          write_d = 1'b0;
          tag_d   = 1'b0;
          st_d    = '0;
          ptr_d   = grant_next;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // One dead cycle lets the finished requester drop its request first.
        done_d  = '0;
        rdata_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      tag_q   <= 1'b0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      read_q  <= read_d;
      write_q <= write_d;
      tag_q   <= tag_d;
      st_q    <= st_d;
    end
  end

`ifdef DCACHE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          error_q, error_d;

  // Counter is zero on the first BUSY cycle and counts every BUSY cycle after.
  always_comb begin
    cnt_d   = (state_q == S_BUSY) ? cnt_q + 1'b1 : '0;
    error_d = (state_q == S_BUSY) && expire && !complete;
  end

  assign expire = (state_q == S_BUSY) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  assign bus.o_req_error = error_q;
`else
  assign expire          = 1'b0;
  assign bus.o_req_error = 1'b0;
`endif

  assign bus.o_req_done         = done_q;
  assign bus.o_req_rdata        = rdata_q;
  assign bus.o_cache_address    = addr_q;
  assign bus.o_cache_dout       = dout_q;
  assign bus.o_cache_read       = read_q;
  assign bus.o_cache_write      = write_q;
  assign bus.o_cache_tag        = tag_q;
  assign bus.o_cache_store_type = st_q;
  assign o_dbg_state            = state_q;
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: reset, single read/store, contention,
// dropped request, mid-transaction reset and the BUSY watchdog.
module tb_dcache_port_arbiter;
  logic       i_clock;
  logic       i_reset_n;
  logic [1:0] dbg_state;
  int         n_tests;
  int         n_fail;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];

  dcache_port_arbiter_if #(.NUM_REQ(2)) bus ();

  dcache_port_arbiter #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge, outputs are sampled there.
  task automatic tick();
    @(posedge i_clock);
    @(negedge i_clock);
  endtask

  task automatic clear_inputs();
    bus.i_req_read       = '0;
    bus.i_req_write      = '0;
    bus.i_req_address    = '0;
    bus.i_req_wdata      = '0;
    bus.i_req_tag        = '0;
    bus.i_req_store_type = '0;
    bus.i_cache_din      = '0;
    bus.i_cache_hit      = 1'b0;
    bus.i_cache_ready    = 1'b0;
  endtask

  task automatic set_read(input int k, input logic [31:0] addr, input logic tag);
    bus.i_req_read[k]              = 1'b1;
    bus.i_req_address[k*32 +: 32]  = addr;
    bus.i_req_tag[k]               = tag;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_done"},  32'(bus.o_req_done), 32'h0);
    check({pfx, "_rdata"}, bus.o_req_rdata, 32'h0);
    check({pfx, "_err"},   32'(bus.o_req_error), 32'h0);
    check({pfx, "_addr"},  bus.o_cache_address, 32'h0);
    check({pfx, "_dout"},  bus.o_cache_dout, 32'h0);
    check({pfx, "_rd"},    32'(bus.o_cache_read), 32'h0);
    check({pfx, "_wr"},    32'(bus.o_cache_write), 32'h0);
    check({pfx, "_tag"},   32'(bus.o_cache_tag), 32'h0);
    check({pfx, "_st"},    32'(bus.o_cache_store_type), 32'h0);
    check({pfx, "_state"}, 32'(dbg_state), 32'h0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear_inputs();
    i_reset_n = 1'b0;
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    check_idle_outputs("reset");
    i_reset_n = 1'b1;

    // Single read, hit arrives two cycles after o_cache_read rises
    set_read(0, 32'h100, 1'b1);
    tick();
    check("rd_read",  32'(bus.o_cache_read), 32'h1);
    check("rd_write", 32'(bus.o_cache_write), 32'h0);
    check("rd_addr",  bus.o_cache_address, 32'h100);
    check("rd_tag",   32'(bus.o_cache_tag), 32'h1);
    check("rd_state", 32'(dbg_state), 32'h1);
    tick();
    check("rd_wait_read", 32'(bus.o_cache_read), 32'h1);
    check("rd_wait_done", 32'(bus.o_req_done), 32'h0);
    bus.i_cache_hit = 1'b1;
    bus.i_cache_din = 32'hDEADBEEF;
    tick();
    check("rd_done",      32'(bus.o_req_done), 32'h1);
    check("rd_rdata",     bus.o_req_rdata, 32'hDEADBEEF);
    check("rd_clr_read",  32'(bus.o_cache_read), 32'h0);
    check("rd_clr_addr",  bus.o_cache_address, 32'h0);
    check("rd_rel_state", 32'(dbg_state), 32'h2);
    clear_inputs();
    tick();
    check("rd_done_pulse", 32'(bus.o_req_done), 32'h0);
    check("rd_rdata_clr",  bus.o_req_rdata, 32'h0);
    check("rd_idle_state", 32'(dbg_state), 32'h0);
    tick();
    check("rd_no_regrant", 32'(bus.o_cache_read), 32'h0);

    // Single store byte from requester 1 (pointer now 1)
    bus.i_req_write[1]           = 1'b1;
    bus.i_req_address[63:32]     = 32'h204;
    bus.i_req_wdata[63:32]       = 32'h55;
    bus.i_req_store_type[3:2]    = 2'd2;
    tick();
    check("st_write", 32'(bus.o_cache_write), 32'h1);
    check("st_read",  32'(bus.o_cache_read), 32'h0);
    check("st_type",  32'(bus.o_cache_store_type), 32'h2);
    check("st_dout",  bus.o_cache_dout, 32'h55);
    check("st_addr",  bus.o_cache_address, 32'h204);
    bus.i_cache_ready = 1'b1;
    tick();
    check("st_done",  32'(bus.o_req_done), 32'h2);
    check("st_rdata", bus.o_req_rdata, 32'h0);
    check("st_clr",   32'(bus.o_cache_write), 32'h0);
    clear_inputs();
    tick();
    check("st_done_pulse", 32'(bus.o_req_done), 32'h0);

    // Contention with permanent requests and immediate hit (pointer now 0)
    for (int c = 0; c < 12; c++) begin
      if (c % 3 == 1) exp_q.push_back(((c / 3) % 2 == 0) ? 32'h1 : 32'h2);
      else            exp_q.push_back(32'h0);
      exp_addr_q.push_back(((c / 3) % 2 == 0) ? 32'h300 : 32'h304);
    end
    set_read(0, 32'h300, 1'b0);
    set_read(1, 32'h304, 1'b1);
    bus.i_cache_hit = 1'b1;
    bus.i_cache_din = 32'h1234;
    for (int c = 0; c < 12; c++) begin
      logic [31:0] e_done;
      logic [31:0] e_addr;
      tick();
      e_done = exp_q.pop_front();
      e_addr = exp_addr_q.pop_front();
      check($sformatf("cont_done_%0d", c), 32'(bus.o_req_done), e_done);
      if (c % 3 == 0) check($sformatf("cont_addr_%0d", c), bus.o_cache_address, e_addr);
      if (c % 3 == 1) check($sformatf("cont_rdata_%0d", c), bus.o_req_rdata, 32'h1234);
    end
    clear_inputs();
    tick();
    check("cont_end_read", 32'(bus.o_cache_read), 32'h0);

    // Read and write both high on one requester behave as a write
    bus.i_req_read[0]        = 1'b1;
    bus.i_req_write[0]       = 1'b1;
    bus.i_req_address[31:0]  = 32'h180;
    bus.i_req_wdata[31:0]    = 32'h77;
    tick();
    check("rw_write", 32'(bus.o_cache_write), 32'h1);
    check("rw_read",  32'(bus.o_cache_read), 32'h0);
    check("rw_dout",  bus.o_cache_dout, 32'h77);
    bus.i_cache_hit = 1'b1;
    tick();
    check("rw_hit_ignored", 32'(bus.o_req_done), 32'h0);
    check("rw_still_write", 32'(bus.o_cache_write), 32'h1);
    bus.i_cache_hit   = 1'b0;
    bus.i_cache_ready = 1'b1;
    tick();
    check("rw_done",  32'(bus.o_req_done), 32'h1);
    check("rw_rdata", bus.o_req_rdata, 32'h0);
    clear_inputs();
    tick();

    // Request dropped mid-BUSY still completes
    set_read(0, 32'h400, 1'b0);
    tick();
    check("drop_read", 32'(bus.o_cache_read), 32'h1);
    bus.i_req_read[0] = 1'b0;
    tick();
    check("drop_hold_read", 32'(bus.o_cache_read), 32'h1);
    check("drop_hold_addr", bus.o_cache_address, 32'h400);
    bus.i_cache_hit = 1'b1;
    bus.i_cache_din = 32'hA5A5;
    tick();
    check("drop_done",  32'(bus.o_req_done), 32'h1);
    check("drop_rdata", bus.o_req_rdata, 32'hA5A5);
    bus.i_cache_hit = 1'b0;
    tick();
    check("drop_done_pulse", 32'(bus.o_req_done), 32'h0);
    tick();
    check("drop_no_regrant", 32'(bus.o_cache_read), 32'h0);

    // Hit and ready with nothing in flight are ignored
    bus.i_cache_hit   = 1'b1;
    bus.i_cache_ready = 1'b1;
    tick();
    check("idle_hit_done",  32'(bus.o_req_done), 32'h0);
    check("idle_hit_state", 32'(dbg_state), 32'h0);
    tick();
    check("idle_hit_done2", 32'(bus.o_req_done), 32'h0);
    clear_inputs();

    // Reset mid-BUSY: outputs clear asynchronously, pointer returns to 0
    set_read(0, 32'h500, 1'b1);
    tick();
    check("rst_busy_read", 32'(bus.o_cache_read), 32'h1);
    #2 i_reset_n = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    @(negedge i_clock);
    check("rst_no_done", 32'(bus.o_req_done), 32'h0);
    i_reset_n = 1'b1;
    set_read(0, 32'h600, 1'b0);
    set_read(1, 32'h604, 1'b0);
    tick();
    check("rst_first_addr", bus.o_cache_address, 32'h600);
    bus.i_cache_hit = 1'b1;
    bus.i_cache_din = 32'h11;
    tick();
    check("rst_done0",  32'(bus.o_req_done), 32'h1);
    check("rst_rdata0", bus.o_req_rdata, 32'h11);
    bus.i_req_read[0] = 1'b0;
    tick();
    tick();
    check("rst_second_addr", bus.o_cache_address, 32'h604);
    tick();
    check("rst_done1", 32'(bus.o_req_done), 32'h2);
    clear_inputs();
    tick();

`ifdef DCACHE_ARB_TIMEOUT_EN
    // Watchdog: no hit, abort after four BUSY cycles
    set_read(0, 32'h700, 1'b0);
    tick();
    check("to_read", 32'(bus.o_cache_read), 32'h1);
    repeat (3) tick();
    check("to_not_yet_done", 32'(bus.o_req_done), 32'h0);
    check("to_not_yet_err",  32'(bus.o_req_error), 32'h0);
    tick();
    check("to_done",     32'(bus.o_req_done), 32'h1);
    check("to_err",      32'(bus.o_req_error), 32'h1);
    check("to_rdata",    bus.o_req_rdata, 32'h0);
    check("to_clr_read", 32'(bus.o_cache_read), 32'h0);
    check("to_clr_addr", bus.o_cache_address, 32'h0);
    clear_inputs();
    tick();
    check("to_err_pulse",  32'(bus.o_req_error), 32'h0);
    check("to_done_pulse", 32'(bus.o_req_done), 32'h0);
`else
    // Without the watchdog BUSY waits indefinitely
    set_read(0, 32'h700, 1'b0);
    repeat (9) tick();
    check("nto_still_read", 32'(bus.o_cache_read), 32'h1);
    check("nto_no_done",    32'(bus.o_req_done), 32'h0);
    check("nto_no_err",     32'(bus.o_req_error), 32'h0);
    bus.i_cache_hit = 1'b1;
    bus.i_cache_din = 32'h99;
    tick();
    check("nto_done",  32'(bus.o_req_done), 32'h1);
    check("nto_rdata", bus.o_req_rdata, 32'h99);
    check("nto_err",   32'(bus.o_req_error), 32'h0);
    clear_inputs();
    tick();
`endif

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
